// File: rtl/cas_pkg.sv
// Shared types and width helpers for the CAS stream reader and its order checker.
package cas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Rank index width; a two-element vector still needs one bit.
  function automatic int rank_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cas_order_check.sv
// Combinational monitor: flags a packed vector that is not non-increasing from element 0.
module cas_order_check #(
  parameter int NUM_INPUTS = 3,
  parameter int WIDTH      = 3
) (
  input  logic [NUM_INPUTS*WIDTH-1:0] data,
  output logic                        bad
);

  // Equal neighbours are legal; only a strict unsigned rise is an error.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_INPUTS - 1; i++) begin
      if (data[i*WIDTH +: WIDTH] < data[(i+1)*WIDTH +: WIDTH]) bad = 1'b1;
    end
  end

endmodule

// File: rtl/cas_stream_reader.sv
// Consumer end of the CAS network: takes one ordered vector per handshake and
// serialises it max-first with rank/last tags, tracking order errors and a vector count.
module cas_stream_reader
  import cas_pkg::*;
#(
  parameter  int NUM_INPUTS = 3,
  parameter  int WIDTH      = 3,
  parameter  int CNT_W      = DEFAULT_CNT_W,
  localparam int RANK_W     = rank_width(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [RANK_W-1:0]           out_rank,
  output logic                        out_last,
  output logic                        order_err,
  output logic                        err_pulse,
  input  logic                        err_clear,
  output logic [CNT_W-1:0]            vec_count
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
    $error("cas_stream_reader: NUM_INPUTS must be in 2..8");
  end

  localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_INPUTS - 1);

  state_t            state_q;
  logic [RANK_W-1:0] rank_q;
  logic [RANK_W-1:0] rank_nx;
  logic [WIDTH-1:0]  vec_q [NUM_INPUTS];
  logic              bad;
  logic              in_fire;
  logic              out_fire;

  cas_order_check #(
    .NUM_INPUTS(NUM_INPUTS),
    .WIDTH     (WIDTH)
  ) u_order_check (
    .data(in_data),
    .bad (bad)
  );

  // Handshake: a transfer happens on valid & ready at a rising edge. in_ready
  // combinationally follows out_ready on the last beat so vectors stream with no bubble.
  assign in_ready = (state_q == IDLE) | ((state_q == EMIT) & out_last & out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign rank_nx  = rank_q + RANK_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rank_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rank  <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) vec_q[i] <= '0;
    end else if (in_fire) begin
      for (int i = 0; i < NUM_INPUTS; i++) vec_q[i] <= in_data[i*WIDTH +: WIDTH];
      state_q   <= EMIT;
      rank_q    <= '0;
      out_valid <= 1'b1;
      out_data  <= in_data[WIDTH-1:0];
      out_rank  <= '0;
      out_last  <= 1'b0;
    end else if (out_fire) begin
      if (out_last) begin
        state_q   <= IDLE;
        out_valid <= 1'b0;
      end else begin
        rank_q   <= rank_nx;
        out_data <= vec_q[rank_nx];
        out_rank <= rank_nx;
        out_last <= (rank_nx == LAST_RANK);
      end
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_err <= 1'b0;
      err_pulse <= 1'b0;
      vec_count <= '0;
    end else begin
      err_pulse <= in_fire & bad;
      if (in_fire & bad)  order_err <= 1'b1;
      else if (err_clear) order_err <= 1'b0;
      if (in_fire) vec_count <= vec_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/cas_stream_reader.md
Name: cas_stream_reader

Overview:
- Consumer end of the CAS sorting network.
- Accepts one ordered vector per handshake (element 0 = max, element NUM_INPUTS-1 = min), checks that it really is non-increasing, and serialises it one element per beat, max first, with rank and last tags.
- Sits between a CAS instance and the serial stochastic datapath in the arch sweep.
- Also keeps a sticky order-error flag and a count of accepted vectors for sweep instrumentation.

Parameters:
- NUM_INPUTS, 3, elements per vector (2..8).
- WIDTH, 3, bits per element.
- CNT_W, 16, width of the accepted-vector counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ordered vector present.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  NUM_INPUTS*WIDTH  element i at bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_rank/out_last valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  WIDTH  current element.
- out_rank  out  RANK_W = max(1, clog2(NUM_INPUTS))  index of current element (0 = max).
- out_last  out  1  high on the rank NUM_INPUTS-1 beat.
- order_err  out  1  sticky: an accepted vector was not non-increasing.
- err_pulse  out  1  one-cycle pulse, cycle after a bad vector is accepted.
- err_clear  in  1  synchronous clear of order_err.
- vec_count  out  CNT_W  number of vectors accepted, unsigned.

Behaviour:
- Reset values (async on rst_n low):
  - state = IDLE, rank = 0, holding buffer = 0.
  - out_valid = 0, out_data = 0, out_rank = 0, out_last = 0.
  - order_err = 0, err_pulse = 0, vec_count = 0.
- Handshakes transfer on valid & ready at a rising edge.
  - in_data is sampled only on an input transfer.
  - out_* must stay stable while out_valid & !out_ready.
- State machine: IDLE, EMIT.
  - IDLE: in_ready = 1, out_valid = 0.
    - On input transfer: capture vector into buffer, rank <= 0, go EMIT.
  - EMIT: out_valid = 1, out_data = buf[rank], out_rank = rank, out_last = (rank == NUM_INPUTS-1).
    - On output transfer with !out_last: rank <= rank + 1.
    - On output transfer with out_last: go IDLE, unless a new vector is accepted in the same cycle.
- Back-to-back: in_ready = (state == IDLE) | (state == EMIT & out_last & out_ready).
  - This is a combinational path from out_ready to in_ready (documented).
  - If the input transfers on the last-beat cycle: capture the new vector, rank <= 0, stay EMIT. Steady-state throughput is one element per cycle with no bubble.
- Latency: the first beat appears the cycle after the input transfer.
- Order check, combinational on in_data:
  - bad = OR over i of (elem[i] < elem[i+1]); comparison is unsigned. Equal neighbours are legal.
  - On an input transfer with bad: order_err <= 1 and err_pulse <= 1 the next cycle. Otherwise err_pulse <= 0.
  - The vector is still emitted unchanged.
  - err_clear clears order_err; if err_clear and a bad transfer occur in the same cycle, set wins.
- vec_count increments on every input transfer and wraps from 2^CNT_W-1 to 0.
- NUM_INPUTS == 1 is illegal (elaboration-time error).
  - For NUM_INPUTS == 2, RANK_W = 1.
  - rank never exceeds NUM_INPUTS-1.
- Reset mid-EMIT drops the in-flight vector: out_valid falls immediately (async) and no partial stream resumes.
- X on in_data while in_valid is low must not propagate to any register.

Decomposition:
- Package cas_pkg:
  - state enum {IDLE, EMIT}.
  - function clog2 and the RANK_W derivation.
  - localparam for the default CNT_W.
- One sub-module, cas_order_check:
  - Combinational; parameters NUM_INPUTS and WIDTH.
  - Input is the packed vector, output is bad.
  - Reusable as a standalone assertion monitor on any CAS output.
- Buffer, FSM and counters stay in cas_stream_reader.

Test Plan:
- NUM_INPUTS=3, WIDTH=3. Send in_data={e2=1, e1=4, e0=6} with out_ready=1 → beats (6,rank0), (4,rank1), (1,rank2,last) on three consecutive cycles; order_err=0; vec_count=1.
- Two vectors back-to-back, {7,5,2} then {3,3,0}, with out_ready=1 → six contiguous beats 7,5,2,3,3,0; in_ready high on the 2-beat; no bubble; equal elements do not flag an error.
- Vector {2,5,1} (e0=2 < e1=5) → err_pulse high for exactly one cycle after acceptance; order_err stays 1; beats 2,5,1 still emitted. Assert err_clear → order_err=0. Apply err_clear together with another bad vector → order_err stays 1.
- Backpressure: out_ready low for 4 cycles mid-vector at rank1 → out_data=4 and out_rank=1 held stable; in_ready=0 throughout; stream resumes correctly.
- Deassert rst_n while at rank1 of {6,4,1} → out_valid=0 and vec_count=0 immediately. After release, a new vector {5,5,5} streams from rank0.
- CNT_W=2: accept 5 vectors → vec_count sequence 1,2,3,0,1.
